// File: rtl/button_conditioner.sv
// Push-button front end: synchronize, debounce and edge-detect start/stop/incre.
// Macro BTN_AUTOREPEAT_EN adds auto-repeat pulses on incre while it is held.
//
// Ports:
//   clk                              rising-edge clock
//   rst                              synchronous reset, active low
//   start_btn, stop_btn, incre_btn   raw asynchronous button levels
//   start_lvl, stop_lvl, incre_lvl   debounced levels
//   start_pulse, stop_pulse,
//   incre_pulse                      one-cycle press strobes
module button_conditioner #(
  parameter int DB_CYCLES    = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic start_btn,
  input  logic stop_btn,
  input  logic incre_btn,
  output logic start_lvl,
  output logic stop_lvl,
  output logic incre_lvl,
  output logic start_pulse,
  output logic stop_pulse,
  output logic incre_pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  // Channel index: 0 start, 1 stop, 2 incre
  logic [2:0]    btn_raw;
  logic [2:0]    meta;
  logic [2:0]    sync;
  logic [2:0]    lvl;
  logic [2:0]    settle;
  logic [2:0]    rise;
  logic [CW-1:0] cnt [3];
  logic          rpt_fire;

  assign btn_raw = {incre_btn, stop_btn, start_btn};

  // settle: this edge commits the synchronized value to the level
  always_comb begin
    settle = '0;
    rise   = '0;
    for (int i = 0; i < 3; i++) begin
      settle[i] = (sync[i] != lvl[i]) && (cnt[i] == CNT_MAX);
      rise[i]   = settle[i] && sync[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '0;
      sync <= '0;
      lvl  <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
      for (int i = 0; i < 3; i++) begin
        if (sync[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (settle[i]) begin
          lvl[i] <= sync[i];
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A simultaneous start+stop press resolves to stop
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      incre_pulse <= 1'b0;
    end else begin
      start_pulse <= rise[0] & ~rise[1];
      stop_pulse  <= rise[1];
      incre_pulse <= rise[2] | rpt_fire;
    end
  end

  assign start_lvl = lvl[0];
  assign stop_lvl  = lvl[1];
  assign incre_lvl = lvl[2];

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_RATE
  } rpt_state_t;

  rpt_state_t    rpt_state;
  rpt_state_t    rpt_state_nxt;
  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_cnt_nxt;
  logic          incre_fall;

  assign incre_fall = settle[2] & ~sync[2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_state <= RPT_IDLE;
      rpt_cnt   <= '0;
    end else begin
      rpt_state <= rpt_state_nxt;
      rpt_cnt   <= rpt_cnt_nxt;
    end
  end

  // rpt_cnt counts edges since the press (DELAY) or last repeat (RATE)
  always_comb begin
    rpt_state_nxt = rpt_state;
    rpt_cnt_nxt   = rpt_cnt;
    rpt_fire      = 1'b0;
    if (rise[2]) begin
      rpt_state_nxt = RPT_DELAY;
      rpt_cnt_nxt   = '0;
    end else if (!lvl[2] || incre_fall) begin
      rpt_state_nxt = RPT_IDLE;
      rpt_cnt_nxt   = '0;
    end else begin
      unique case (rpt_state)
        RPT_DELAY: begin
          if (rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
            rpt_fire      = 1'b1;
            rpt_state_nxt = RPT_RATE;
            rpt_cnt_nxt   = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + RW'(1);
          end
        end
        RPT_RATE: begin
          if (rpt_cnt == RW'(REPEAT_RATE - 1)) begin
            rpt_fire    = 1'b1;
            rpt_cnt_nxt = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + RW'(1);
          end
        end
        default: begin
          rpt_state_nxt = RPT_IDLE;
          rpt_cnt_nxt   = '0;
        end
      endcase
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner against a history-based model.
// Covers reset, debounce latency, glitches, start/stop priority, repeat, abort.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam int EXP_INC = 8;
`else
  localparam int EXP_INC = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_btn = 1'b0;
  logic stop_btn = 1'b0;
  logic incre_btn = 1'b0;
  logic start_lvl, stop_lvl, incre_lvl;
  logic start_pulse, stop_pulse, incre_pulse;
  logic [5:0] obs;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .DB_CYCLES   (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .stop_btn   (stop_btn),
    .incre_btn  (incre_btn),
    .start_lvl  (start_lvl),
    .stop_lvl   (stop_lvl),
    .incre_lvl  (incre_lvl),
    .start_pulse(start_pulse),
    .stop_pulse (stop_pulse),
    .incre_pulse(incre_pulse)
  );

  always #5 clk = ~clk;

  assign obs = {start_lvl, stop_lvl, incre_lvl,
                start_pulse, stop_pulse, incre_pulse};

  // Model: raw samples reach the logic two edges late; a level flips
  // once the last DB samples seen all differ from it.
  bit [2:0] rawq[$];
  bit [2:0] seenq[$];
  bit [2:0] m_lvl;
  bit [2:0] m_pul;
  int       n_edge;
  int       rise_edge;
  bit       rep_on;

  function automatic void model_edge(bit r, bit [2:0] b);
    bit [2:0] seen;
    bit [2:0] nl;
    bit [2:0] rs;
    bit [2:0] fl;
    bit       all_diff;
    int       d;
    n_edge++;
    if (!r) begin
      rawq.delete();
      seenq.delete();
      m_lvl  = '0;
      m_pul  = '0;
      rep_on = 1'b0;
      return;
    end
    seen = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 3'b000;
    rawq.push_back(b);
    seenq.push_back(seen);
    nl = m_lvl;
    for (int ch = 0; ch < 3; ch++) begin
      if (seenq.size() >= DB) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DB; k++)
          if (seenq[seenq.size()-k][ch] == m_lvl[ch]) all_diff = 1'b0;
        if (all_diff) nl[ch] = ~m_lvl[ch];
      end
    end
    rs = nl & ~m_lvl;
    fl = ~nl & m_lvl;
    m_lvl = nl;
    if (rs[2]) begin
      rep_on = 1'b1;
      rise_edge = n_edge;
    end
    if (fl[2]) rep_on = 1'b0;
    m_pul[0] = rs[0] & ~rs[1];
    m_pul[1] = rs[1];
    m_pul[2] = rs[2];
`ifdef BTN_AUTOREPEAT_EN
    if (rep_on && m_lvl[2]) begin
      d = n_edge - rise_edge;
      if (d >= RD && ((d - RD) % RR) == 0) m_pul[2] = 1'b1;
    end
`else
    d = 0;
`endif
    if (rawq.size() > 8) void'(rawq.pop_front());
    if (seenq.size() > DB + 4) void'(seenq.pop_front());
  endfunction

  function automatic logic [5:0] expv();
    return {m_lvl[0], m_lvl[1], m_lvl[2], m_pul[0], m_pul[1], m_pul[2]};
  endfunction

  task automatic cycle(input bit r, input bit [2:0] b);
    rst = r;
    {incre_btn, stop_btn, start_btn} = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 3'b000);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL idle cyc %0d: got %b want %b", i, obs, expv());
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'b000);
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("FAIL reset_low cyc %0d: got %b want 000000", i, obs);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 3'b000);
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("FAIL reset_after cyc %0d: got %b want 000000", i, obs);
      end
    end
  endtask

  task automatic test_start_press();
    int rise_at = -1;
    int pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 3'b001);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL start_press cyc %0d: got %b want %b", i, obs, expv());
      end
      if (start_lvl === 1'b1 && rise_at < 0) rise_at = i;
      if (start_pulse === 1'b1) pulses++;
    end
    checks++;
    if (rise_at != 6) begin
      errors++;
      $display("FAIL start_latency: got edge %0d want 6", rise_at);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL start_pulse_count: got %0d want 1", pulses);
    end
    test_idle();
  endtask

  task automatic test_glitch();
    int seen_hi = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, (i < 3) ? 3'b010 : 3'b000);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL glitch cyc %0d: got %b want %b", i, obs, expv());
      end
      if (stop_lvl === 1'b1 || stop_pulse === 1'b1) seen_hi++;
    end
    checks++;
    if (seen_hi != 0) begin
      errors++;
      $display("FAIL glitch_stop: got %0d high cycles want 0", seen_hi);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 3'b011);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL simult cyc %0d: got %b want %b", i, obs, expv());
      end
      if (i == 6) begin
        checks++;
        if ({start_lvl, stop_lvl, start_pulse, stop_pulse} !== 4'b1101) begin
          errors++;
          $display("FAIL simult_priority: got %b want 1101",
                   {start_lvl, stop_lvl, start_pulse, stop_pulse});
        end
      end
    end
    test_idle();
  endtask

  task automatic test_incre_hold();
    int pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b1, (i <= 30) ? 3'b100 : 3'b000);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL incre_hold cyc %0d: got %b want %b", i, obs, expv());
      end
      if (incre_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != EXP_INC) begin
      errors++;
      $display("FAIL incre_pulse_count: got %0d want %0d", pulses, EXP_INC);
    end
  endtask

  task automatic test_reset_abort();
    int pulse_at = -1;
    int pulses = 0;
    for (int i = 0; i < 7; i++) begin
      cycle((i >= 2) ? 1'b0 : 1'b1, 3'b001);
      checks++;
      if (obs !== expv() || start_pulse !== 1'b0) begin
        errors++;
        $display("FAIL abort_during cyc %0d: got %b want %b", i, obs, expv());
      end
    end
    for (int i = 1; i <= 14; i++) begin
      cycle(1'b1, 3'b001);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL abort_after cyc %0d: got %b want %b", i, obs, expv());
      end
      if (start_pulse === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    checks++;
    if (pulse_at != 6 || pulses != 1) begin
      errors++;
      $display("FAIL abort_pulse: got edge %0d count %0d want 6 and 1",
               pulse_at, pulses);
    end
    test_idle();
  endtask

  task automatic test_random();
    bit [2:0] b = '0;
    bit       r;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 99) < 8) b[0] = ~b[0];
      if ($urandom_range(0, 99) < 8) b[1] = ~b[1];
      if ($urandom_range(0, 99) < 3) b[2] = ~b[2];
      r = ($urandom_range(0, 249) != 0);
      cycle(r, b);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b want %b", i, obs, expv());
      end
    end
    test_idle();
  endtask

  initial begin
    m_lvl = '0;
    m_pul = '0;
    n_edge = 0;
    rise_edge = 0;
    rep_on = 1'b0;
    test_reset();
    test_start_press();
    test_glitch();
    test_simultaneous();
    test_incre_hold();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
